hdr_ddr_target_rx: RTL and testbench

Target-side I3C HDR-DDR word receiver. It is the receiving end of the controller's HDR-DDR command/data/CRC sequence.
- Deserialises SDA bits sampled on both SCL edges into 20-bit words.
- Checks preambles, parity and the trailing CRC5 word.
- Presents decoded command fields and write-data words to the target register interface.
- Sits between the SCL edge detector / HDR pattern detector and the target regfile and Tx engine.

---
 rtl/hdr_ddr_pkg.sv | 41 ++++
 rtl/hdr_ddr_crc5.sv | 28 ++
 rtl/hdr_ddr_target_rx.sv | 185 ++++++++++++++++++
 tb/tb_hdr_ddr_target_rx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdr_ddr_pkg.sv
// Shared definitions for the I3C HDR-DDR word path (target Rx and controller Tx).
package hdr_ddr_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD_PRE,
        ST_CMD_WORD,
        ST_CMD_PAR,
        ST_DATA_PRE,
        ST_DATA_WORD,
        ST_DATA_PAR,
        ST_CRC_TOKEN,
        ST_CRC_VAL,
        ST_WAIT_EXIT
    } rx_state_e;

    localparam int PRE_BITS     = 2;
    localparam int PAYLOAD_BITS = 16;
    localparam int PARITY_BITS  = 2;
    localparam int TOKEN_BITS   = 4;
    localparam int CRC_BITS     = 5;

    localparam logic [PRE_BITS-1:0]   PRE_CMD   = 2'b01;
    localparam logic [PRE_BITS-1:0]   PRE_DATA  = 2'b10;
    localparam logic [PRE_BITS-1:0]   PRE_CRC   = 2'b01;
    localparam logic [TOKEN_BITS-1:0] CRC_TOKEN = 4'b1100;

    // {PA1, PA0}: PA1 over odd payload bits, PA0 over even bits, inverted.
    function automatic logic [PARITY_BITS-1:0] ddr_parity(input logic [PAYLOAD_BITS-1:0] payload);
        logic pa1;
        logic pa0;
        pa1 = 1'b0;
        pa0 = 1'b1;
        for (int i = 0; i < PAYLOAD_BITS / 2; i++) begin
            pa1 = pa1 ^ payload[2*i+1];
            pa0 = pa0 ^ payload[2*i];
        end
        return {pa1, pa0};
    endfunction

endpackage

// File: rtl/hdr_ddr_crc5.sv
// Serial CRC5 (x^5+x^2+1) LFSR, shared by the HDR-DDR Rx and Tx engines.
module hdr_ddr_crc5
    import hdr_ddr_pkg::*;
#(
    parameter logic [CRC_BITS-1:0] CRC_INIT = 5'h1F
) (
    input  logic                i_sys_clk,
    input  logic                i_sys_rst,
    input  logic                i_init,
    input  logic                i_en,
    input  logic                i_bit,
    output logic [CRC_BITS-1:0] o_crc
);

    logic fb;
    assign fb = o_crc[CRC_BITS-1] ^ i_bit;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            o_crc <= CRC_INIT;
        end else if (i_init) begin
            o_crc <= CRC_INIT;
        end else if (i_en) begin
            o_crc <= {o_crc[CRC_BITS-2:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
    end

endmodule

// File: rtl/hdr_ddr_target_rx.sv
// I3C HDR-DDR target word receiver: deserialises command/data/CRC words and flags errors.
// Define HDR_DDR_RX_CRC_CHECK_EN to accumulate and check the trailing CRC5.
module hdr_ddr_target_rx
    import hdr_ddr_pkg::*;
#(
    parameter int          DATA_WORDS_MAX = 8,
    parameter logic [4:0]  CRC_INIT       = 5'h1F
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_en,
    input  logic        i_sda,
    input  logic        i_scl_pos_edge,
    input  logic        i_scl_neg_edge,
    input  logic        i_hdr_restart,
    input  logic        i_hdr_exit,
    input  logic [6:0]  i_dyn_addr,
    output logic        o_cmd_valid,
    output logic        o_rnw,
    output logic [6:0]  o_cmd_code,
    output logic        o_addr_match,
    output logic        o_read_req,
    output logic [15:0] o_data,
    output logic        o_data_valid,
    output logic        o_parity_err,
    output logic        o_frame_err,
    output logic        o_crc_err,
    output logic        o_frame_done
);

    localparam int SHIFT_W = PAYLOAD_BITS + PARITY_BITS - 1;
    localparam int WCNT_W  = $clog2(DATA_WORDS_MAX + 2);
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(DATA_WORDS_MAX + 1);

    rx_state_e          state;
    logic [SHIFT_W-1:0] shift_q;
    logic [4:0]         bit_cnt;
    logic [4:0]         state_len;
    logic [WCNT_W-1:0]  word_cnt;
    logic [WCNT_W-1:0]  word_cnt_nxt;
    logic [SHIFT_W:0]   word;
    logic               strobe;
    logic               last_bit;
    logic               addr_hit;
    logic               crc_bad;

    assign strobe       = i_scl_pos_edge | i_scl_neg_edge;
    // Window ending on the current bit: payload at [17:2], parity at [1:0].
    assign word         = {shift_q, i_sda};
    assign addr_hit     = (word[9:3] == i_dyn_addr);
    assign word_cnt_nxt = word_cnt + WCNT_W'(1);
    assign last_bit     = strobe && (bit_cnt == state_len - 5'd1);

    always_comb begin
        state_len = 5'(PRE_BITS);
        case (state)
            ST_CMD_WORD, ST_DATA_WORD: state_len = 5'(PAYLOAD_BITS);
            ST_CMD_PAR, ST_DATA_PAR:   state_len = 5'(PARITY_BITS);
            ST_CRC_TOKEN:              state_len = 5'(TOKEN_BITS);
            ST_CRC_VAL:                state_len = 5'(CRC_BITS);
            default:                   state_len = 5'(PRE_BITS);
        endcase
    end

`ifdef HDR_DDR_RX_CRC_CHECK_EN
    logic [CRC_BITS-1:0] crc;
    logic                crc_init;
    logic                crc_shift;

    assign crc_init  = !i_en || i_hdr_exit || i_hdr_restart || (state == ST_IDLE);
    assign crc_shift = strobe && (state == ST_CMD_WORD || state == ST_DATA_WORD);
    assign crc_bad   = (word[CRC_BITS-1:0] != crc);

    hdr_ddr_crc5 #(.CRC_INIT(CRC_INIT)) u_crc5 (
        .i_sys_clk (i_sys_clk),
        .i_sys_rst (i_sys_rst),
        .i_init    (crc_init),
        .i_en      (crc_shift),
        .i_bit     (i_sda),
        .o_crc     (crc)
    );
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state        <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            o_cmd_valid  <= 1'b0;
            o_rnw        <= 1'b0;
            o_cmd_code   <= '0;
            o_addr_match <= 1'b0;
            o_read_req   <= 1'b0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_crc_err    <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_cmd_valid  <= 1'b0;
            o_read_req   <= 1'b0;
            o_data_valid <= 1'b0;
            o_frame_done <= 1'b0;
            // NOTE: disable/exit/restart are checked before strobes so a bit landing in the same cycle is dropped.
            if (!i_en || i_hdr_exit || i_hdr_restart) begin
                state        <= (!i_en || i_hdr_exit) ? ST_IDLE : ST_CMD_PRE;
                bit_cnt      <= '0;
                word_cnt     <= '0;
                o_parity_err <= 1'b0;
                o_frame_err  <= 1'b0;
                o_crc_err    <= 1'b0;
            end else if (strobe) begin
                shift_q <= word[SHIFT_W-1:0];
                bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
                case (state)
                    // The entry edge out of IDLE carries no frame bit.
                    ST_IDLE: begin
                        state   <= ST_CMD_PRE;
                        bit_cnt <= '0;
                    end
                    ST_CMD_PRE: if (last_bit) begin
                        if (word[1:0] == PRE_CMD) begin
                            state <= ST_CMD_WORD;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= ST_WAIT_EXIT;
                        end
                    end
                    ST_CMD_WORD: if (last_bit) state <= ST_CMD_PAR;
                    ST_CMD_PAR: if (last_bit) begin
                        o_cmd_valid  <= 1'b1;
                        o_rnw        <= word[17];
                        o_cmd_code   <= word[16:10];
                        o_addr_match <= addr_hit;
                        if (ddr_parity(word[17:2]) != word[1:0]) o_parity_err <= 1'b1;
                        if (word[17]) begin
                            o_read_req <= addr_hit;
                            state      <= ST_WAIT_EXIT;
                        end else begin
                            state <= ST_DATA_PRE;
                        end
                    end
                    ST_DATA_PRE: if (last_bit) begin
                        if (word[1:0] == PRE_DATA) begin
                            state <= ST_DATA_WORD;
                        end else if (word[1:0] == PRE_CRC) begin
                            state <= ST_CRC_TOKEN;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= ST_WAIT_EXIT;
                        end
                    end
                    ST_DATA_WORD: if (last_bit) state <= ST_DATA_PAR;
                    ST_DATA_PAR: if (last_bit) begin
                        word_cnt <= word_cnt_nxt;
                        if (ddr_parity(word[17:2]) != word[1:0]) o_parity_err <= 1'b1;
                        if (word_cnt_nxt == WCNT_LIMIT) begin
                            o_frame_err <= 1'b1;
                            state       <= ST_WAIT_EXIT;
                        end else begin
                            if (o_addr_match) o_data <= word[17:2];
                            o_data_valid <= o_addr_match;
                            state        <= ST_DATA_PRE;
                        end
                    end
                    ST_CRC_TOKEN: if (last_bit) begin
                        if (word[TOKEN_BITS-1:0] != CRC_TOKEN) o_frame_err <= 1'b1;
                        state <= ST_CRC_VAL;
                    end
                    ST_CRC_VAL: if (last_bit) begin
                        if (crc_bad) o_crc_err <= 1'b1;
                        o_frame_done <= 1'b1;
                        state        <= ST_WAIT_EXIT;
                    end
                    default: bit_cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdr_ddr_target_rx.sv
// Directed/randomised bench for hdr_ddr_target_rx against a frame-level reference model.
module tb_hdr_ddr_target_rx;

    localparam int         DATA_WORDS_MAX = 8;
    localparam logic [4:0] CRC_INIT       = 5'h1F;
`ifdef HDR_DDR_RX_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sda = 1'b0;
    logic        scl_pos = 1'b0;
    logic        scl_neg = 1'b0;
    logic        restart = 1'b0;
    logic        hexit = 1'b0;
    logic [6:0]  dyn_addr = 7'h2A;
    logic        cmd_valid, rnw, addr_match, read_req, data_valid;
    logic        parity_err, frame_err, crc_err, frame_done;
    logic [6:0]  cmd_code;
    logic [15:0] data;

    always #5 clk = ~clk;

    hdr_ddr_target_rx #(.DATA_WORDS_MAX(DATA_WORDS_MAX), .CRC_INIT(CRC_INIT)) dut (
        .i_sys_clk      (clk),
        .i_sys_rst      (rst_n),
        .i_en           (en),
        .i_sda          (sda),
        .i_scl_pos_edge (scl_pos),
        .i_scl_neg_edge (scl_neg),
        .i_hdr_restart  (restart),
        .i_hdr_exit     (hexit),
        .i_dyn_addr     (dyn_addr),
        .o_cmd_valid    (cmd_valid),
        .o_rnw          (rnw),
        .o_cmd_code     (cmd_code),
        .o_addr_match   (addr_match),
        .o_read_req     (read_req),
        .o_data         (data),
        .o_data_valid   (data_valid),
        .o_parity_err   (parity_err),
        .o_frame_err    (frame_err),
        .o_crc_err      (crc_err),
        .o_frame_done   (frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit edge_sel = 1'b0;

    // Reference model state for the current frame.
    bit m_bits[$];
    int m_words = 0;
    bit m_match = 1'b0;
    bit m_par_err = 1'b0;
    bit m_frame_err = 1'b0;
    bit m_crc_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_parity(input logic [15:0] p);
        logic [1:0] r;
        r[1] = ($countones(p & 16'hAAAA) % 2) == 1;
        r[0] = ($countones(p & 16'h5555) % 2) == 0;
        return r;
    endfunction

    function automatic logic [4:0] ref_crc();
        logic [4:0] c;
        logic       fb;
        c = CRC_INIT;
        foreach (m_bits[i]) begin
            fb = c[4] ^ m_bits[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return c;
    endfunction

    function automatic void model_clear();
        m_bits.delete();
        m_words     = 0;
        m_par_err   = 1'b0;
        m_frame_err = 1'b0;
        m_crc_err   = 1'b0;
    endfunction

    task automatic strobe_bit(input logic b);
        @(negedge clk);
        sda = b;
        if ($urandom_range(7) == 0) begin
            scl_pos = 1'b1;
            scl_neg = 1'b1;
        end else if (edge_sel) begin
            scl_pos = 1'b1;
        end else begin
            scl_neg = 1'b1;
        end
        edge_sel = !edge_sel;
        @(negedge clk);
        scl_pos = 1'b0;
        scl_neg = 1'b0;
    endtask

    task automatic send_bits(input logic [19:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) strobe_bit(bits[i]);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {cmd_valid, rnw, cmd_code, addr_match, read_req, data, data_valid,
                    parity_err, frame_err, crc_err, frame_done}, 32'h0);
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check({tag, ".pulses_low"}, {cmd_valid, read_req, data_valid, frame_done}, 32'h0);
    endtask

    task automatic check_errs(input string tag);
        check({tag, ".errs"}, {parity_err, frame_err, crc_err}, {m_par_err, m_frame_err, m_crc_err});
    endtask

    task automatic do_cmd(input string tag, input logic r, input logic [6:0] code,
                          input logic [6:0] addr, input logic bad_par);
        logic [15:0] p;
        logic [1:0]  par;
        p   = {r, code, addr, 1'($urandom_range(1))};
        par = ref_parity(p) ^ {1'b0, bad_par};
        send_bits({2'b01, p, par}, 20);
        m_match   = (addr == dyn_addr);
        m_par_err = m_par_err | bad_par;
        for (int i = 15; i >= 0; i--) m_bits.push_back(p[i]);
        check({tag, ".cmd_valid"}, cmd_valid, 1);
        check({tag, ".rnw"}, rnw, r);
        check({tag, ".code"}, cmd_code, code);
        check({tag, ".match"}, addr_match, m_match);
        check({tag, ".read_req"}, read_req, r & m_match);
        check({tag, ".par_err"}, parity_err, m_par_err);
    endtask

    task automatic do_data(input string tag, input logic [15:0] p, input logic bad_par);
        logic [1:0] par;
        bit         exp_valid;
        par = ref_parity(p) ^ {1'b0, bad_par};
        send_bits({2'b10, p, par}, 20);
        m_words++;
        m_par_err = m_par_err | bad_par;
        for (int i = 15; i >= 0; i--) m_bits.push_back(p[i]);
        if (m_words > DATA_WORDS_MAX) begin
            m_frame_err = 1'b1;
            exp_valid   = 1'b0;
        end else begin
            exp_valid = m_match;
        end
        check({tag, ".data_valid"}, data_valid, exp_valid);
        if (exp_valid) check({tag, ".data"}, data, p);
        check({tag, ".par_err"}, parity_err, m_par_err);
        check({tag, ".frame_err"}, frame_err, m_frame_err);
    endtask

    task automatic do_crc(input string tag, input logic [3:0] token, input bit flip);
        logic [4:0] c;
        c = ref_crc();
        if (flip) c = c ^ (5'b00001 << $urandom_range(4));
        send_bits({9'b0, 2'b01, token, c}, 11);
        if (token != 4'b1100) m_frame_err = 1'b1;
        if (CRC_ON && flip) m_crc_err = 1'b1;
        check({tag, ".frame_done"}, frame_done, 1);
        check_errs(tag);
    endtask

    task automatic do_restart(input string tag);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        model_clear();
        check_errs(tag);
    endtask

    task automatic do_exit(input string tag);
        @(negedge clk);
        hexit = 1'b1;
        @(negedge clk);
        hexit = 1'b0;
        model_clear();
        check_errs(tag);
    endtask

    initial begin
        en = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        strobe_bit(1'b0);
        check_all_zero("entry");

        // Write frame: command, data words, good CRC.
        do_cmd("wr_cmd", 1'b0, 7'h20, 7'h2A, 1'b0);
        check_quiet("wr_cmd");
        do_data("d1234", 16'h1234, 1'b0);
        repeat (3) do_data("drand", 16'($urandom), 1'b0);
        do_data("d1234_badpar", 16'h1234, 1'b1);
        do_crc("crc_ok", 4'b1100, 1'b0);
        check_quiet("crc_ok");
        send_bits({2'b10, 16'hBEEF, 2'b00}, 20);
        check("wait_ignored", {data_valid, cmd_valid, frame_done}, 32'h0);

        // Second frame with a corrupted CRC bit.
        do_restart("rs1");
        do_cmd("wr2", 1'b0, 7'($urandom), 7'h2A, 1'b0);
        repeat (2) do_data("d2", 16'($urandom), 1'b0);
        do_crc("crc_flip", 4'b1100, 1'b1);

        // Reads: matched hands off to Tx, unmatched does not.
        do_restart("rs2");
        do_cmd("rd_match", 1'b1, 7'($urandom), 7'h2A, 1'b0);
        check_quiet("rd_match");
        send_bits({2'b10, 16'h5A5A, 2'b00}, 20);
        check("rd_wait_ignored", {data_valid, cmd_valid}, 32'h0);
        do_restart("rs3");
        do_cmd("rd_miss", 1'b1, 7'($urandom), 7'h11, 1'b0);
        do_restart("rs4");

        // Write to another target: data not presented.
        do_cmd("wr_miss", 1'b0, 7'($urandom), 7'h33, 1'b0);
        do_data("d_miss", 16'($urandom), 1'b0);
        do_crc("crc_miss", 4'b1100, 1'b0);
        do_restart("rs5");

        // Word overflow on the (DATA_WORDS_MAX+1)th data word.
        do_cmd("wr_ovf", 1'b0, 7'($urandom), 7'h2A, 1'b0);
        for (int i = 0; i <= DATA_WORDS_MAX; i++) do_data("d_ovf", 16'($urandom), 1'b0);
        do_restart("rs6");

        // Bad command preamble.
        send_bits({2'b10, 16'h0000, 2'b00}, 20);
        check("bad_cmd_pre.frame_err", frame_err, 1);
        check("bad_cmd_pre.cmd_valid", cmd_valid, 0);
        do_restart("rs7");

        // Bad data preamble, later strobes ignored, then exit.
        do_cmd("wr3", 1'b0, 7'($urandom), 7'h2A, 1'b0);
        send_bits({2'b11, 16'hCAFE, 2'b00}, 20);
        check("bad_data_pre.frame_err", frame_err, 1);
        check("bad_data_pre.data_valid", data_valid, 0);
        send_bits({9'b0, 2'b01, 4'b1100, 5'h00}, 11);
        check("bad_data_pre.ignored", frame_done, 0);
        do_exit("exit1");
        strobe_bit(1'b0);
        do_cmd("wr_after_exit", 1'b0, 7'($urandom), 7'h2A, 1'b0);
        do_data("d_after_exit", 16'($urandom), 1'b0);
        do_crc("bad_token", 4'b1010, 1'b0);
        do_restart("rs8");

        // Enable dropped mid-frame behaves like exit.
        do_cmd("wr_en", 1'b0, 7'($urandom), 7'h2A, 1'b1);
        send_bits({12'h0, 2'b10, 6'h2B}, 8);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        model_clear();
        check_errs("en_low");
        strobe_bit(1'b0);
        do_cmd("wr_after_en", 1'b0, 7'($urandom), 7'h2A, 1'b0);

        // Asynchronous reset in the middle of a data word.
        do_data("d_pre_rst", 16'($urandom), 1'b0);
        send_bits({12'h0, 2'b10, 6'h15}, 8);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
